// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle shift-subtract divider sequencer for the EX stage.
// Optional macro DIV_BYZERO_FLAG_EN adds the dbz_o divide-by-zero flag.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
`ifdef DIV_BYZERO_FLAG_EN
    output logic               dbz_o,
`endif
    output logic               stallreq_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]   part_q, part_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] fin_q, fin_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               accept;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     upper;
    logic [WIDTH:0]     dv_ext;
    logic               ge;
    logic [2*WIDTH:0]   step;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept     = (state_q == FREE) & start_i & ~annul_i;
    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

    // Operand magnitudes and one restoring iteration on the partial register
    always_comb begin
        a_mag = (signed_div_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        b_mag = (signed_div_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        upper  = part_q[2*WIDTH-1:WIDTH-1];
        dv_ext = {1'b0, dvsr_q};
        ge     = part_q[2*WIDTH] | (upper >= dv_ext);
        if (ge) begin
            step = {upper - dv_ext, part_q[WIDTH-2:0], 1'b1};
        end else begin
            step = {upper, part_q[WIDTH-2:0], 1'b0};
        end
        quo_raw = step[WIDTH-1:0];
        rem_raw = step[2*WIDTH-1:WIDTH];
        quo_fix = neg_quo_q ? -quo_raw : quo_raw;
        rem_fix = neg_rem_q ? -rem_raw : rem_raw;
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        part_d    = part_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        fin_d     = fin_q;
        result_d  = '0;
        ready_d   = 1'b0;
        unique case (state_q)
            FREE: begin
                if (accept) begin
                    part_d    = {{(WIDTH+1){1'b0}}, a_mag};
                    dvsr_d    = b_mag;
                    neg_quo_d = signed_div_i
                              & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d = signed_div_i & opdata1_i[WIDTH-1];
                    cnt_d     = '0;
                    fin_d     = '0;
                    state_d   = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d = FREE;
                end else begin
                    fin_d   = '0;
                    state_d = END;
                end
            end
            ON: begin
                if (annul_i) begin
                    cnt_d   = '0;
                    state_d = FREE;
                end else begin
                    part_d = step;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        fin_d   = {rem_fix, quo_fix};
                        cnt_d   = '0;
                        state_d = END;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            END: begin
                if (start_i) begin
                    ready_d  = 1'b1;
                    result_d = fin_q;
                end else begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            part_q    <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            fin_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            fin_q     <= fin_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

`ifdef DIV_BYZERO_FLAG_EN
    logic zero_q, zero_d;

    // Remember whether the accepted divisor was zero
    always_comb begin
        zero_d = zero_q;
        if (accept) begin
            zero_d = (opdata2_i == '0);
        end
    end

    // Zero-divisor flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign dbz_o = ready_q & zero_q;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized self-checking bench for div_ctrl
// against an arithmetic reference model.
module tb_div_ctrl;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           stallreq_o;
`ifdef DIV_BYZERO_FLAG_EN
    logic           dbz_o;
`endif

    int n_chk = 0;
    int n_bad = 0;

    div_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
`ifdef DIV_BYZERO_FLAG_EN
        .dbz_o        (dbz_o),
`endif
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_div(input bit s,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic do_div(input bit s, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        logic [63:0] held;
        int lat;
        exp = ref_div(s, a, b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_at_accept", {63'd0, stallreq_o}, 64'd1);
        @(negedge clk);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            chk("ready_timeout", 64'd0, 64'd1);
        end else begin
            chk("latency", 64'(lat), (b == 0) ? 64'd2 : 64'(W + 1));
            chk("result", result_o, exp);
            chk("stall_at_ready", {63'd0, stallreq_o}, 64'd0);
`ifdef DIV_BYZERO_FLAG_EN
            chk("dbz", {63'd0, dbz_o}, {63'd0, (b == 0)});
`endif
            held = result_o;
            repeat (2) @(posedge clk);
            #1;
            chk("hold_result", result_o, held);
            chk("hold_ready", {63'd0, ready_o}, 64'd1);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_ready", {63'd0, ready_o}, 64'd0);
        chk("drop_result", result_o, 64'd0);
`ifdef DIV_BYZERO_FLAG_EN
        chk("drop_dbz", {63'd0, dbz_o}, 64'd0);
`endif
    endtask

    initial begin
        bit seen;
        bit s;
        logic [31:0] a, b;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div(1'b0, 32'd5, 32'd0);
        do_div(1'b1, 32'hFFFF_FFF0, 32'd0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE);

        // annul at iteration 10
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        chk("annul_result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        chk("annul_no_ready", {63'd0, seen}, 64'd0);
        do_div(1'b0, 32'd1000, 32'd3);

        // annul held in FREE blocks acceptance
        @(negedge clk);
        start_i = 1'b1;
        annul_i = 1'b1;
        opdata2_i = 32'd9;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        chk("annul_free_block", {63'd0, seen}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;

        // reset at iteration 20
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'hDEAD_BEEF;
        opdata2_i    = 32'd13;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", {63'd0, ready_o}, 64'd0);
        chk("midrst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        do_div(1'b1, 32'hDEAD_BEEF, 32'd13);

        // randomized divisions with boundary values mixed in
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: b = $urandom_range(1, 15);
                default: ;
            endcase
            do_div(s, a, b);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
